// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the 32 x 8 memory test interface.
// Accepts single-cycle read/write strobes, stores writes in an internal array,
// returns read data on a tri-stated bus one edge after the read strobe,
// flags read/write collisions (sticky) and counts completed accesses.
//
// Optional feature macro: MEM_PARITY_EN
//   defined   -> each word carries an even-parity bit, par_flip injects a
//                parity error on write, parity_err reports a mismatch for the
//                DRIVE cycle of the offending read.
//   undefined -> no parity storage, par_flip/parity_err ports absent.
module mem_responder #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MEM_PARITY_EN
  input  logic              par_flip,
  output logic              parity_err,
`endif
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output tri   [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              proto_err,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_e;

  // A collision is neither a read nor a write: memory and counters untouched.
  logic wr_fire, rd_fire, coll;
  assign wr_fire = write & ~read;
  assign rd_fire = read & ~write;
  assign coll    = read & write;

  logic [MEM_W-1:0] mem_q [DEPTH];
  logic [MEM_W-1:0] wr_word_d;
  logic [MEM_W-1:0] rd_word;

`ifdef MEM_PARITY_EN
  // Stored bit makes the word's total parity even; par_flip corrupts it.
  assign wr_word_d = {(^data_in) ^ par_flip, data_in};
`else
  assign wr_word_d = data_in;
`endif
  assign rd_word = mem_q[addr];

  state_e            state_q;
  logic              rd_valid_q;
  logic              proto_err_q;
  logic [DATA_W-1:0] rd_q;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

  // Saturating next-count values; only applied on a completed access.
  assign wr_cnt_d = (wr_cnt_q == CNT_MAX) ? wr_cnt_q : wr_cnt_q + CNT_ONE;
  assign rd_cnt_d = (rd_cnt_q == CNT_MAX) ? rd_cnt_q : rd_cnt_q + CNT_ONE;

  // Array is not reset: contents survive rst_n and are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[addr] <= wr_word_d;
  end

  // Responder FSM with registered outputs; rd_valid and the bus enable both
  // come from rd_valid_q so they change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_valid_q  <= 1'b0;
      proto_err_q <= 1'b0;
      rd_q        <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      if (coll) proto_err_q <= 1'b1;
      if (wr_fire) wr_cnt_q <= wr_cnt_d;
      if (rd_fire) begin
        rd_q     <= rd_word[DATA_W-1:0];
        rd_cnt_q <= rd_cnt_d;
      end
      case (state_q)
        S_IDLE, S_DRIVE: begin
          if (rd_fire) begin
            state_q    <= S_DRIVE;
            rd_valid_q <= 1'b1;
          end else begin
            state_q    <= S_IDLE;
            rd_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          rd_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_PARITY_EN
  logic par_err_q;

  // Parity check result belongs to the DRIVE cycle of the read that caused it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= rd_fire & (^rd_word);
  end

  assign parity_err = par_err_q;
`endif

  assign data_out  = rd_valid_q ? rd_q : {DATA_W{1'bz}};
  assign rd_valid  = rd_valid_q;
  assign proto_err = proto_err_q;
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a driver pushes the expected read result
// when it issues a read; a negedge monitor pops and compares when rd_valid is
// due, and checks counters / proto_err against a small reference model.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       read, write;
  logic [4:0] addr;
  logic [7:0] data_in;
  wire  [7:0] data_out;
  logic       rd_valid, proto_err;
  logic [15:0] wr_count, rd_count;
`ifdef MEM_PARITY_EN
  logic       par_flip;
  logic       parity_err;
`endif

  mem_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MEM_PARITY_EN
    .par_flip  (par_flip),
    .parity_err(parity_err),
`endif
    .read      (read),
    .write     (write),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .rd_valid  (rd_valid),
    .proto_err (proto_err),
    .wr_count  (wr_count),
    .rd_count  (rd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         known;
    bit         perr;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl [32];
  bit         mknown [32];
  bit         mpar [32];
  int         exp_wr, exp_rd;
  bit         exp_perr;
  bit         in_rst;
  int         n_chk, n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One strobe cycle: inputs change just after the falling edge, sampled at
  // the following rising edge; the model is updated with the same decision.
  task automatic do_op(input bit r, input bit w, input logic [4:0] a,
                       input logic [7:0] d, input bit pf);
    exp_t e;
    @(negedge clk); #1;
    read = r; write = w; addr = a; data_in = d;
`ifdef MEM_PARITY_EN
    par_flip = pf;
`endif
    if (r && w) exp_perr = 1'b1;
    else if (w) begin
      mdl[a] = d; mknown[a] = 1'b1; mpar[a] = pf;
      if (exp_wr != 65535) exp_wr++;
    end else if (r) begin
      e.d = mdl[a]; e.known = mknown[a]; e.perr = mpar[a];
      exp_q.push_back(e);
      if (exp_rd != 65535) exp_rd++;
    end
  endtask

  task automatic idle();
    do_op(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
  endtask

  // Monitor: runs at every falling edge, i.e. mid-cycle after the DUT updated.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!in_rst) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_valid", {31'd0, rd_valid}, 32'd1);
        if (e.known) chk("rdata", {24'd0, data_out}, {24'd0, e.d});
`ifdef MEM_PARITY_EN
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
`endif
      end else begin
        chk("idle_valid", {31'd0, rd_valid}, 32'd0);
`ifdef MEM_PARITY_EN
        chk("idle_perr", {31'd0, parity_err}, 32'd0);
`endif
      end
      chk("wr_count", {16'd0, wr_count}, exp_wr);
      chk("rd_count", {16'd0, rd_count}, exp_rd);
      chk("proto_err", {31'd0, proto_err}, {31'd0, exp_perr});
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rdv"},  {31'd0, rd_valid}, 32'd0);
    chk({tag, "_perr"}, {31'd0, proto_err}, 32'd0);
    chk({tag, "_wrc"},  {16'd0, wr_count}, 32'd0);
    chk({tag, "_rdc"},  {16'd0, rd_count}, 32'd0);
`ifdef MEM_PARITY_EN
    chk({tag, "_par"},  {31'd0, parity_err}, 32'd0);
`endif
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    exp_wr = 0; exp_rd = 0; exp_perr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mknown[i] = 1'b0; mpar[i] = 1'b0; mdl[i] = 8'h00;
    end
    in_rst = 1'b1;
    rst_n = 1'b0; read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
`ifdef MEM_PARITY_EN
    par_flip = 1'b0;
`endif
    #3;
    chk_reset_state("rst0");
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b1; in_rst = 1'b0;

    // Clear test: write zeros everywhere, then read back-to-back.
    for (int a = 0; a < 32; a++) do_op(1'b0, 1'b1, 5'(a), 8'h00, 1'b0);
    for (int a = 0; a < 32; a++) do_op(1'b1, 1'b0, 5'(a), 8'h00, 1'b0);
    idle();
    @(negedge clk); #2;
    chk("clr_wrc", {16'd0, wr_count}, 32'd32);
    chk("clr_rdc", {16'd0, rd_count}, 32'd32);

    // Data = address, reads separated by idle cycles.
    for (int a = 0; a < 32; a++) do_op(1'b0, 1'b1, 5'(a), 8'(a), 1'b0);
    for (int a = 0; a < 32; a++) begin
      do_op(1'b1, 1'b0, 5'(a), 8'h00, 1'b0);
      idle();
    end

    // Collision: memory untouched, counters unchanged, sticky proto_err.
    do_op(1'b0, 1'b1, 5'd3, 8'hA5, 1'b0);
    do_op(1'b1, 1'b1, 5'd3, 8'h5A, 1'b0);
    idle();
    idle();
    do_op(1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
    idle();

    // Read-after-write on consecutive edges.
    do_op(1'b0, 1'b1, 5'd31, 8'h3C, 1'b0);
    do_op(1'b1, 1'b0, 5'd31, 8'h00, 1'b0);
    idle();

    // Reset while in DRIVE: outputs clear immediately, array survives.
    do_op(1'b1, 1'b0, 5'd7, 8'h00, 1'b0);
    @(posedge clk); #2;
    chk("pre_rst_rdv", {31'd0, rd_valid}, 32'd1);
    chk("pre_rst_data", {24'd0, data_out}, 32'h07);
    in_rst = 1'b1;
    rst_n = 1'b0; read = 1'b0; write = 1'b0;
    exp_q.delete();
    exp_wr = 0; exp_rd = 0; exp_perr = 1'b0;
    #1;
    chk_reset_state("midrst");
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b1; in_rst = 1'b0;
    do_op(1'b1, 1'b0, 5'd7, 8'h00, 1'b0);
    idle();
    do_op(1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
    do_op(1'b1, 1'b0, 5'd31, 8'h00, 1'b0);
    idle();

`ifdef MEM_PARITY_EN
    // Parity injection then clean rewrite.
    do_op(1'b0, 1'b1, 5'd9, 8'h0F, 1'b1);
    do_op(1'b1, 1'b0, 5'd9, 8'h00, 1'b0);
    idle();
    do_op(1'b0, 1'b1, 5'd9, 8'h0F, 1'b0);
    do_op(1'b1, 1'b0, 5'd9, 8'h00, 1'b0);
    idle();
`endif

    idle();
    idle();
    @(negedge clk); #2;
    chk("q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
